// File: rtl/spi_master_cfg.sv
// Configurable full-duplex SPI master: one word per accepted start, run-time CPOL/CPHA,
// per-word D/C flag and chip-select hold across bursts.
module spi_master_cfg #(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 16,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dc_in,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              keep_cs,
  input  logic [DIV_W-1:0]  div_factor,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic              sce,
  output logic              dc,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              avail
);
  localparam int EW = $clog2(2*DATA_W+1);
  localparam logic [EW-1:0] LAST_E = EW'(2*DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
  state_t state;

  logic [DATA_W-1:0] tx, rx, rx_next;
  logic [DIV_W-1:0]  h, cnt;
  logic [EW-1:0]     ecnt, edge_idx;
  logic              cpol_q, cpha_q, keep_q;
  logic              accept, tick, do_edge, sample;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shifted(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign accept   = start && (state == IDLE || state == DONE);
  assign tick     = (cnt == h - DIV_W'(1));
  // The end of SETUP is itself edge 0, so SHIFT spans exactly 2*DATA_W half-periods.
  assign edge_idx = (state == SETUP) ? '0 : ecnt;
  assign do_edge  = tick && ((state == SETUP) || (state == SHIFT && ecnt != LAST_E));
  // Even edges lead; cpha decides whether leading or trailing edges sample.
  assign sample   = (~edge_idx[0]) ^ cpha_q;
  assign rx_next  = LSB_FIRST ? {miso, rx[DATA_W-1:1]} : {rx[DATA_W-2:0], miso};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sclk     <= 1'b0;
      sce      <= 1'b1;
      mosi     <= 1'b0;
      dc       <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
      avail    <= 1'b0;
      keep_q   <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      h        <= DIV_W'(1);
      cnt      <= '0;
      ecnt     <= '0;
      tx       <= '0;
      rx       <= '0;
    end else begin
      avail <= 1'b0;
      if (accept) begin
        state  <= SETUP;
        busy   <= 1'b1;
        sce    <= 1'b0;
        dc     <= dc_in;
        cpol_q <= cpol;
        cpha_q <= cpha;
        keep_q <= keep_cs;
        h      <= (div_factor == '0) ? DIV_W'(1) : div_factor;
        sclk   <= cpol;
        cnt    <= '0;
        ecnt   <= '0;
        rx     <= '0;
        if (!cpha) begin
          mosi <= first_bit(data_in);
          tx   <= shifted(data_in);
        end else begin
          tx   <= data_in;
        end
      end else begin
        case (state)
          IDLE: begin
            sclk <= cpol;
            sce  <= ~keep_q;
          end
          SETUP: begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
            if (tick) state <= SHIFT;
          end
          SHIFT: begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
            if (tick && ecnt == LAST_E) state <= HOLD;
          end
          HOLD: begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
            if (tick) begin
              state    <= DONE;
              data_out <= rx;
              avail    <= 1'b1;
              busy     <= 1'b0;
              sce      <= ~keep_q;
            end
          end
          DONE: begin
            state <= IDLE;
            sclk  <= cpol;
            sce   <= ~keep_q;
          end
          default: state <= IDLE;
        endcase
        if (do_edge) begin
          sclk <= ~sclk;
          ecnt <= edge_idx + EW'(1);
          if (sample) begin
            rx <= rx_next;
          end else if (edge_idx != LAST_E - EW'(1)) begin
            // No new bit after the final trailing edge: mosi keeps the last bit through HOLD.
            mosi <= first_bit(tx);
            tx   <= shifted(tx);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: SPI modes, bursts, back-to-back accept, mid-word reset,
// and an LSB-first 9-bit instance with div_factor=0.
module tb_spi_master_cfg;
  logic       clk = 1'b0;
  logic       reset, start, dc_in, cpol, cpha, keep_cs, miso;
  logic [7:0] data_in;
  logic [15:0] div_factor;
  logic       mosi, sclk, sce, dc, busy, avail;
  logic [7:0] data_out;

  logic       start2, miso2;
  logic [8:0] data_in2;
  logic [15:0] div_factor2;
  logic       mosi2, sclk2, sce2, dc2, busy2, avail2;
  logic [8:0] data_out2;

  int passed = 0;
  int total  = 0;

  // slave / monitor state shared by launch and watch
  logic [7:0] mbits, sword;
  logic       echo, pol, prev_sclk, sce_hi;
  int         avk, bi;

  always #5 clk = ~clk;

  spi_master_cfg #(.DATA_W(8), .DIV_W(16), .LSB_FIRST(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .dc_in(dc_in),
    .cpol(cpol), .cpha(cpha), .keep_cs(keep_cs), .div_factor(div_factor), .miso(miso),
    .mosi(mosi), .sclk(sclk), .sce(sce), .dc(dc), .data_out(data_out),
    .busy(busy), .avail(avail)
  );

  spi_master_cfg #(.DATA_W(9), .DIV_W(16), .LSB_FIRST(1'b1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .data_in(data_in2), .dc_in(dc_in),
    .cpol(cpol), .cpha(cpha), .keep_cs(keep_cs), .div_factor(div_factor2), .miso(miso2),
    .mosi(mosi2), .sclk(sclk2), .sce(sce2), .dc(dc2), .data_out(data_out2),
    .busy(busy2), .avail(avail2)
  );

  task automatic launch(input logic [7:0] d, input logic pol_i, input logic pha_i,
                        input logic dc_i, input logic kc_i, input logic [15:0] div,
                        input logic hammer);
    @(negedge clk);
    data_in = d; cpol = pol_i; cpha = pha_i; dc_in = dc_i; keep_cs = kc_i;
    div_factor = div; pol = pol_i; prev_sclk = sclk; start = 1'b1;
    @(posedge clk);
    #1;
    if (hammer) data_in = 8'h00;
    else start = 1'b0;
  endtask

  // Steps from cycle k0 until avail (or budget); records mosi at each leading sclk edge.
  task automatic watch(input int k0, input int budget);
    avk = -1; mbits = '0; bi = 0; sce_hi = 1'b0;
    for (int k = k0; k < k0 + budget; k++) begin
      @(negedge clk);
      if (busy && prev_sclk == pol && sclk != pol) begin
        mbits = {mbits[6:0], mosi};
        if (!echo && bi < 8) begin
          miso = sword[7-bi];
          bi++;
        end
      end
      if (echo) miso = ~mosi;
      prev_sclk = sclk;
      if (avail) begin
        avk = k;
        break;
      end
      if (sce) sce_hi = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; data_in = '0; dc_in = 1'b0; cpol = 1'b0; cpha = 1'b0;
    keep_cs = 1'b0; div_factor = '0; miso = 1'b0;
    start2 = 1'b0; data_in2 = '0; div_factor2 = '0; miso2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (sce !== 1'b1) $display("FAIL rst_sce: got %b want 1", sce); else passed++;
    total++; if (sclk !== 1'b0) $display("FAIL rst_sclk: got %b want 0", sclk); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (avail !== 1'b0) $display("FAIL rst_avail: got %b want 0", avail); else passed++;
    total++; if (mosi !== 1'b0 || dc !== 1'b0) $display("FAIL rst_mosi_dc: got %b%b want 00", mosi, dc); else passed++;
    total++; if (data_out !== 8'h00) $display("FAIL rst_data_out: got %h want 00", data_out); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mode0;
    echo = 1'b1;
    launch(8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0);
    watch(1, 200);
    total++; if (avk !== 73) $display("FAIL m0_avail_cycle: got %0d want 73", avk); else passed++;
    total++; if (mbits !== 8'hA3) $display("FAIL m0_mosi_bits: got %h want a3", mbits); else passed++;
    total++; if (data_out !== 8'h5C) $display("FAIL m0_data_out: got %h want 5c", data_out); else passed++;
    total++; if (sce !== 1'b1) $display("FAIL m0_sce_done: got %b want 1", sce); else passed++;
    total++; if (sce_hi !== 1'b0) $display("FAIL m0_sce_low: got %b want 0", sce_hi); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL m0_busy_done: got %b want 0", busy); else passed++;
    total++; if (dc !== 1'b1) $display("FAIL m0_dc: got %b want 1", dc); else passed++;
    @(negedge clk);
    total++; if (avail !== 1'b0) $display("FAIL m0_avail_width: got %b want 0", avail); else passed++;
  endtask

  task automatic test_mode3;
    @(negedge clk);
    cpol = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (sclk !== 1'b1) $display("FAIL m3_idle_sclk: got %b want 1", sclk); else passed++;
    echo = 1'b0; sword = 8'hC5;
    launch(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 1'b0);
    watch(1, 200);
    total++; if (avk !== 73) $display("FAIL m3_avail_cycle: got %0d want 73", avk); else passed++;
    total++; if (mbits !== 8'h3C) $display("FAIL m3_mosi_bits: got %h want 3c", mbits); else passed++;
    total++; if (data_out !== 8'hC5) $display("FAIL m3_data_out: got %h want c5", data_out); else passed++;
    total++; if (sclk !== 1'b1) $display("FAIL m3_sclk_done: got %b want 1", sclk); else passed++;
  endtask

  task automatic test_burst;
    logic gap_hi;
    echo = 1'b1;
    launch(8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0);
    watch(1, 200);
    total++; if (avk !== 37) $display("FAIL b1_avail_cycle: got %0d want 37", avk); else passed++;
    total++; if (data_out !== 8'hDF) $display("FAIL b1_data_out: got %h want df", data_out); else passed++;
    total++; if (dc !== 1'b0) $display("FAIL b1_dc: got %b want 0", dc); else passed++;
    total++; if ((sce_hi | sce) !== 1'b0) $display("FAIL b1_sce_low: got %b want 0", sce_hi | sce); else passed++;
    gap_hi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sce) gap_hi = 1'b1;
    end
    total++; if (gap_hi !== 1'b0) $display("FAIL burst_gap_sce: got %b want 0", gap_hi); else passed++;
    launch(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0);
    watch(1, 200);
    total++; if (avk !== 37) $display("FAIL b2_avail_cycle: got %0d want 37", avk); else passed++;
    total++; if (data_out !== 8'h00) $display("FAIL b2_data_out: got %h want 00", data_out); else passed++;
    total++; if (dc !== 1'b1) $display("FAIL b2_dc: got %b want 1", dc); else passed++;
    total++; if (sce_hi !== 1'b0) $display("FAIL b2_sce_low: got %b want 0", sce_hi); else passed++;
    total++; if (sce !== 1'b1) $display("FAIL b2_sce_release: got %b want 1", sce); else passed++;
  endtask

  task automatic test_back_to_back;
    echo = 1'b1;
    launch(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 1'b1);
    watch(1, 200);
    total++; if (avk !== 73) $display("FAIL bb1_avail_cycle: got %0d want 73", avk); else passed++;
    total++; if (mbits !== 8'h96) $display("FAIL bb1_mosi_bits: got %h want 96", mbits); else passed++;
    total++; if (data_out !== 8'h69) $display("FAIL bb1_data_out: got %h want 69", data_out); else passed++;
    @(negedge clk);
    if (echo) miso = ~mosi;
    prev_sclk = sclk;
    total++; if (busy !== 1'b1) $display("FAIL bb_accept_in_done: got %b want 1", busy); else passed++;
    total++; if (avail !== 1'b0) $display("FAIL bb_avail_width: got %b want 0", avail); else passed++;
    start = 1'b0;
    watch(2, 200);
    total++; if (avk !== 73) $display("FAIL bb2_avail_cycle: got %0d want 73", avk); else passed++;
    total++; if (data_out !== 8'hFF) $display("FAIL bb2_data_out: got %h want ff", data_out); else passed++;
    total++; if (mbits !== 8'h00) $display("FAIL bb2_mosi_bits: got %h want 00", mbits); else passed++;
  endtask

  task automatic test_reset_mid;
    logic seen;
    echo = 1'b1;
    launch(8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0);
    repeat (20) @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL rm_busy_c20: got %b want 1", busy); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++; if (sce !== 1'b1) $display("FAIL rm_sce: got %b want 1", sce); else passed++;
    total++; if (sclk !== 1'b0) $display("FAIL rm_sclk: got %b want 0", sclk); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else passed++;
    total++; if (data_out !== 8'h00) $display("FAIL rm_data_out: got %h want 00", data_out); else passed++;
    reset = 1'b0;
    seen = avail;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (avail) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL rm_no_avail: got %b want 0", seen); else passed++;
  endtask

  task automatic test_lsb_div0;
    logic [8:0] seq;
    logic       p2;
    int         k2;
    seq = '0; k2 = -1;
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; keep_cs = 1'b0; dc_in = 1'b0;
    data_in2 = 9'h101; div_factor2 = 16'd0; start2 = 1'b1; p2 = sclk2;
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int k = 1; k < 80; k++) begin
      @(negedge clk);
      if (busy2 && p2 == 1'b0 && sclk2 == 1'b1) seq = {seq[7:0], mosi2};
      miso2 = ~mosi2;
      p2 = sclk2;
      if (avail2) begin
        k2 = k;
        break;
      end
    end
    total++; if (k2 !== 21) $display("FAIL lsb_avail_cycle: got %0d want 21", k2); else passed++;
    total++; if (seq !== 9'h101) $display("FAIL lsb_mosi_bits: got %h want 101", seq); else passed++;
    total++; if (data_out2 !== 9'h0FE) $display("FAIL lsb_data_out: got %h want 0fe", data_out2); else passed++;
    total++; if (sce2 !== 1'b1 || busy2 !== 1'b0) $display("FAIL lsb_done_sce_busy: got %b%b want 10", sce2, busy2); else passed++;
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_mode3;
    test_burst;
    test_back_to_back;
    test_reset_mid;
    test_lsb_div0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
